// File: rtl/loop_controller.sv
// loop_controller: bracket sequencer that tracks the return-address stack and forward-skip nesting, and drives the PC load.
module loop_controller #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid,
    input  logic                     op_open,
    input  logic                     op_close,
    input  logic                     cell_zero,
    input  logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        pc_next,
    output logic                     pc_load,
    output logic                     skip,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     error
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [ADDR_W:0] NEST1 = (ADDR_W+1)'(1);
    typedef enum logic [1:0] {RUN, SKIP, FLUSH, ERROR} state_t;
    state_t state;
    logic [ADDR_W:0] nest;
    logic [ADDR_W-1:0] stack [DEPTH];
    logic [ADDR_W-1:0] top;
    logic acc, run_acc, full, empty, push, fault;
    always_comb begin
        acc = valid && (state == RUN || state == SKIP);
        run_acc = acc && state == RUN;
        full = depth == FULL;
        empty = depth == '0;
        push = run_acc && op_open && !op_close && !cell_zero && !full;
        fault = (acc && op_open && op_close) || (run_acc && ((op_open && !cell_zero && full) || (op_close && empty)));
        top = stack[PW'(depth - 1'b1)];
    end
    always_ff @(posedge clk)
        if (push)
            stack[PW'(depth)] <= pc;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= RUN;
            nest <= '0;
            pc_next <= '0;
            pc_load <= 1'b0;
            skip <= 1'b0;
            depth <= '0;
            error <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            if (fault) begin
                state <= ERROR;
                error <= 1'b1;
                skip <= 1'b1;
            end else begin
                case (state)
                    RUN:
                        if (valid && op_open) begin
                            if (cell_zero) begin
                                state <= SKIP;
                                nest <= NEST1;
                                skip <= 1'b1;
                            end else
                                depth <= depth + 1'b1;
                        end else if (valid && op_close) begin
                            if (cell_zero)
                                depth <= depth - 1'b1;
                            else begin
                                pc_next <= top + 1'b1;
                                pc_load <= 1'b1;
                                state <= FLUSH;
                            end
                        end
                    SKIP:
                        if (valid && op_open)
                            nest <= nest + 1'b1;
                        else if (valid && op_close) begin
                            if (nest == NEST1) begin
                                state <= RUN;
                                nest <= '0;
                                skip <= 1'b0;
                            end else
                                nest <= nest - 1'b1;
                        end
                    FLUSH: state <= RUN;
                    default: ;
                endcase
            end
        end
endmodule

// File: tb/tb_loop_controller.sv
// tb_loop_controller: directed table, corner sequences and randomized traffic against a queue-based model.
module tb_loop_controller;
    logic clk = 1'b0, reset = 1'b1;
    logic valid = 1'b0, op_open = 1'b0, op_close = 1'b0, cell_zero = 1'b0;
    logic [7:0] pc = '0, pc_next;
    logic pc_load, skip, error;
    logic [4:0] depth;
    int checks = 0, errors = 0;
    int mq[$];
    int mnest, mnext;
    bit merr, mflush, mload;
    typedef struct {
        bit v, o, c, z;
        int p;
        bit ld;
        int nx;
        bit sk;
        int dp;
        bit er;
    } vec_t;
    vec_t tbl[13];

    loop_controller #(.ADDR_W(8), .DEPTH(16)) dut (
        .clk(clk), .reset(reset), .valid(valid), .op_open(op_open), .op_close(op_close),
        .cell_zero(cell_zero), .pc(pc), .pc_next(pc_next), .pc_load(pc_load),
        .skip(skip), .depth(depth), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mnest = 0;
        mnext = 0;
        merr = 0;
        mflush = 0;
        mload = 0;
    endtask

    task automatic model_step(input bit v, o, c, z, input int p);
        mload = 0;
        if (merr) ;
        else if (mflush) mflush = 0;
        else if (v) begin
            if (o && c) merr = 1;
            else if (mnest > 0) begin
                if (o) mnest++;
                else if (c) mnest--;
            end else if (o) begin
                if (z) mnest = 1;
                else if (mq.size() == 16) merr = 1;
                else mq.push_back(p);
            end else if (c) begin
                if (mq.size() == 0) merr = 1;
                else if (z) void'(mq.pop_back());
                else begin
                    mload = 1;
                    mnext = (mq[$] + 1) % 256;
                    mflush = 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, o, c, z, input int p);
        valid = v;
        op_open = o;
        op_close = c;
        cell_zero = z;
        pc = p[7:0];
        model_step(v, o, c, z, p);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("pc_load", int'(pc_load), int'(mload));
        if (mload) chk("pc_next", int'(pc_next), mnext);
        chk("skip", int'(skip), int'(merr || mnest > 0));
        chk("depth", int'(depth), mq.size());
        chk("error", int'(error), int'(merr));
    endtask

    task automatic do_reset();
        valid = 1'b0;
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{1,1,0,0, 3, 0,0, 0,1,0};
        tbl[1]  = '{1,0,1,0, 7, 1,4, 0,1,0};
        tbl[2]  = '{1,1,0,0, 8, 0,0, 0,1,0};
        tbl[3]  = '{1,0,1,1, 7, 0,0, 0,0,0};
        tbl[4]  = '{1,1,0,1, 2, 0,0, 1,0,0};
        tbl[5]  = '{1,1,0,0, 3, 0,0, 1,0,0};
        tbl[6]  = '{1,1,0,1, 4, 0,0, 1,0,0};
        tbl[7]  = '{1,0,1,0, 5, 0,0, 1,0,0};
        tbl[8]  = '{1,0,1,1, 6, 0,0, 1,0,0};
        tbl[9]  = '{1,0,1,0, 7, 0,0, 0,0,0};
        tbl[10] = '{0,1,1,0, 8, 0,0, 0,0,0};
        tbl[11] = '{1,0,1,0, 20, 0,0, 1,0,1};
        tbl[12] = '{1,0,1,0, 21, 0,0, 1,0,1};
        model_reset();
        #12 reset = 1'b0;
        #1;
        chk("reset pc_next", int'(pc_next), 0);
        chk("reset pc_load", int'(pc_load), 0);
        chk("reset skip", int'(skip), 0);
        chk("reset depth", int'(depth), 0);
        chk("reset error", int'(error), 0);

        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].v, tbl[i].o, tbl[i].c, tbl[i].z, tbl[i].p);
            chk($sformatf("tbl%0d pc_load", i), int'(pc_load), int'(tbl[i].ld));
            if (tbl[i].ld) chk($sformatf("tbl%0d pc_next", i), int'(pc_next), tbl[i].nx);
            chk($sformatf("tbl%0d skip", i), int'(skip), int'(tbl[i].sk));
            chk($sformatf("tbl%0d depth", i), int'(depth), tbl[i].dp);
            chk($sformatf("tbl%0d error", i), int'(error), int'(tbl[i].er));
        end

        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 10 + i);
        chk("ovf depth16", int'(depth), 16);
        chk("ovf no error", int'(error), 0);
        cycle(1, 1, 0, 0, 40);
        chk("ovf error", int'(error), 1);
        chk("ovf depth held", int'(depth), 16);
        chk("ovf skip", int'(skip), 1);
        cycle(1, 0, 1, 0, 41);
        chk("ovf no load", int'(pc_load), 0);
        cycle(0, 0, 0, 0, 0);
        chk("ovf no load 2", int'(pc_load), 0);

        do_reset();
        cycle(1, 1, 1, 0, 5);
        chk("illegal error", int'(error), 1);
        check_model();

        do_reset();
        cycle(1, 1, 0, 1, 2);
        cycle(1, 1, 0, 0, 3);
        cycle(1, 1, 0, 0, 4);
        chk("pre-reset skip", int'(skip), 1);
        #2 reset = 1'b1;
        #1;
        chk("async pc_next", int'(pc_next), 0);
        chk("async pc_load", int'(pc_load), 0);
        chk("async skip", int'(skip), 0);
        chk("async depth", int'(depth), 0);
        chk("async error", int'(error), 0);
        #2 reset = 1'b0;
        model_reset();
        cycle(1, 1, 0, 0, 9);
        chk("post-reset depth", int'(depth), 1);
        chk("post-reset skip", int'(skip), 0);

        cycle(1, 0, 1, 0, 12);
        chk("back2back first load", int'(pc_load), 1);
        chk("back2back target", int'(pc_next), 10);
        cycle(1, 0, 1, 0, 12);
        chk("back2back dropped", int'(pc_load), 0);
        chk("back2back depth", int'(depth), 1);

        for (int r = 0; r < 12; r++) begin
            do_reset();
            for (int k = 0; k < 120; k++) begin
                int sel;
                bit o, c;
                sel = $urandom_range(0, 99);
                o = sel < 45 || sel == 99;
                c = (sel >= 45 && sel < 85) || sel == 99;
                cycle($urandom_range(0, 3) != 0, o, c, $urandom_range(0, 9) < 3, $urandom_range(0, 255));
                check_model();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
